// File: rtl/multi_dot_painter_pkg.sv
// Shared types and helpers for the multi-dot painter: motion mode encodings,
// the packed RGB pixel type and saturating colour arithmetic.
package multi_dot_painter_pkg;

    localparam logic MODE_RASTER = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;
    localparam int   COORD_W     = 6;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic rgb24_t rgb_sat_add(input rgb24_t a, input rgb24_t b);
        rgb24_t s;
        s.r = sat_add8(a.r, b.r);
        s.g = sat_add8(a.g, b.g);
        s.b = sat_add8(a.b, b.b);
        return s;
    endfunction

endpackage

// File: rtl/dot_walker.sv
// One dot: position, bounce direction and stepping (RASTER or BOUNCE).
// With DOT_TRAIL_EN defined it also keeps the previous position and a valid bit.
module dot_walker
    import multi_dot_painter_pkg::*;
#(
    parameter int                 WIDTH   = 64,
    parameter int                 HEIGHT  = 64,
    parameter logic [COORD_W-1:0] RESET_Y = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               mode,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y
`ifdef DOT_TRAIL_EN
    ,
    output logic [COORD_W-1:0] trail_x,
    output logic [COORD_W-1:0] trail_y,
    output logic               trail_vld
`endif
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

    logic               dx_neg, dy_neg;
    logic               nxt_dx_neg, nxt_dy_neg;
    logic [COORD_W-1:0] nxt_x, nxt_y;

    always_comb begin
        nxt_x      = pos_x;
        nxt_y      = pos_y;
        nxt_dx_neg = dx_neg;
        nxt_dy_neg = dy_neg;
        if (mode == MODE_RASTER) begin
            if (pos_x == X_MAX) begin
                nxt_x = '0;
                nxt_y = (pos_y == Y_MAX) ? '0 : pos_y + 1'b1;
            end else begin
                nxt_x = pos_x + 1'b1;
            end
        end else begin
            // Hitting a wall flips the sign and still moves one step inward.
            if (!dx_neg) begin
                if (pos_x == X_MAX) begin
                    nxt_dx_neg = 1'b1;
                    nxt_x      = pos_x - 1'b1;
                end else begin
                    nxt_x = pos_x + 1'b1;
                end
            end else begin
                if (pos_x == '0) begin
                    nxt_dx_neg = 1'b0;
                    nxt_x      = pos_x + 1'b1;
                end else begin
                    nxt_x = pos_x - 1'b1;
                end
            end
            if (!dy_neg) begin
                if (pos_y == Y_MAX) begin
                    nxt_dy_neg = 1'b1;
                    nxt_y      = pos_y - 1'b1;
                end else begin
                    nxt_y = pos_y + 1'b1;
                end
            end else begin
                if (pos_y == '0) begin
                    nxt_dy_neg = 1'b0;
                    nxt_y      = pos_y + 1'b1;
                end else begin
                    nxt_y = pos_y - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x  <= '0;
            pos_y  <= RESET_Y;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
        end else if (step) begin
            pos_x  <= nxt_x;
            pos_y  <= nxt_y;
            dx_neg <= nxt_dx_neg;
            dy_neg <= nxt_dy_neg;
        end
    end

`ifdef DOT_TRAIL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trail_x   <= '0;
            trail_y   <= '0;
            trail_vld <= 1'b0;
        end else if (step) begin
            trail_x   <= pos_x;
            trail_y   <= pos_y;
            trail_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/multi_dot_painter.sv
// Paints NUM_DOTS moving dots: shared tick divider, frame-change detect and a
// saturating colour sum per pixel. Optional half-intensity trails via DOT_TRAIL_EN.
module multi_dot_painter
    import multi_dot_painter_pkg::*;
#(
    parameter int                      NUM_DOTS   = 4,
    parameter int                      WIDTH      = 64,
    parameter int                      HEIGHT     = 64,
    parameter int                      FRAME_BITS = 13,
    parameter int                      DIV_MAX    = 240000,
    parameter logic [NUM_DOTS-1:0]     TICK_SEL   = 4'b1010,
    parameter logic [24*NUM_DOTS-1:0]  DOT_COLORS = {24'hC80000, 24'h00C800, 24'h0000C8, 24'hC8C800}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic [7:0]            subframe,
    input  logic [COORD_W-1:0]    x,
    input  logic [COORD_W-1:0]    y,
    input  logic                  run,
    input  logic [NUM_DOTS-1:0]   dot_mode,
    output logic [23:0]           rgb24
);

    localparam int DIV_W = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);

    logic [DIV_W-1:0]      div_cnt;
    logic                  div_tick;
    logic [FRAME_BITS-1:0] last_frame;
    logic                  frame_tick;
    logic [NUM_DOTS-1:0]   step;

    logic [NUM_DOTS-1:0][COORD_W-1:0] dot_x, dot_y;
`ifdef DOT_TRAIL_EN
    logic [NUM_DOTS-1:0][COORD_W-1:0] trl_x, trl_y;
    logic [NUM_DOTS-1:0]              trl_vld;
`endif

    // The subframe index is part of the panel interface but does not affect dots.
    logic unused_subframe;
    assign unused_subframe = ^subframe;

    assign div_tick   = (div_cnt == DIV_W'(DIV_MAX));
    assign frame_tick = (frame != last_frame);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            last_frame <= '0;
        end else begin
            div_cnt    <= div_tick ? '0 : div_cnt + 1'b1;
            last_frame <= frame;
        end
    end

    for (genvar i = 0; i < NUM_DOTS; i++) begin : g_dot
        // Ticks seen while run is low are simply dropped.
        assign step[i] = run & (TICK_SEL[i] ? frame_tick : div_tick);

        dot_walker #(
            .WIDTH   (WIDTH),
            .HEIGHT  (HEIGHT),
            .RESET_Y (COORD_W'((2 * i) % HEIGHT))
        ) u_dot (
            .clk       (clk),
            .reset     (reset),
            .step      (step[i]),
            .mode      (dot_mode[i]),
            .pos_x     (dot_x[i]),
            .pos_y     (dot_y[i])
`ifdef DOT_TRAIL_EN
            ,
            .trail_x   (trl_x[i]),
            .trail_y   (trl_y[i]),
            .trail_vld (trl_vld[i])
`endif
        );
    end

    rgb24_t acc;
    rgb24_t col;

    always_comb begin
        acc = '0;
        col = '0;
        for (int i = 0; i < NUM_DOTS; i++) begin
            col = DOT_COLORS[i*24 +: 24];
            if (dot_x[i] == x && dot_y[i] == y)
                acc = rgb_sat_add(acc, col);
`ifdef DOT_TRAIL_EN
            if (trl_vld[i] && trl_x[i] == x && trl_y[i] == y)
                acc = rgb_sat_add(acc, rgb24_t'((col >> 1) & 24'h7F7F7F));
`endif
        end
        rgb24 = acc;
    end

endmodule

// File: tb/tb_multi_dot_painter.sv
// Directed bench for multi_dot_painter (DIV_MAX=3, dots 0/1 red C80000,
// dot 2 green, dot 3 blue); trail expectations follow DOT_TRAIL_EN.
module tb_multi_dot_painter;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x, y;
    logic        run;
    logic [3:0]  dot_mode;
    logic [23:0] rgb24;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DOT_TRAIL_EN
    localparam logic [23:0] TR0 = 24'h640000;
`else
    localparam logic [23:0] TR0 = 24'h000000;
`endif

    multi_dot_painter #(
        .NUM_DOTS   (4),
        .WIDTH      (64),
        .HEIGHT     (64),
        .FRAME_BITS (13),
        .DIV_MAX    (3),
        .TICK_SEL   (4'b1010),
        .DOT_COLORS ({24'h0000C8, 24'h00C800, 24'hC80000, 24'hC80000})
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .frame    (frame),
        .subframe (subframe),
        .x        (x),
        .y        (y),
        .run      (run),
        .dot_mode (dot_mode),
        .rgb24    (rgb24)
    );

    always #5 clk = ~clk;

    task automatic probe(input int px, input int py);
        x = px[5:0];
        y = py[5:0];
        #1;
    endtask

    task automatic do_reset(input logic r, input logic [3:0] m);
        reset = 1'b1; run = r; dot_mode = m; frame = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; run = 1'b1; dot_mode = '0; frame = '0; subframe = 8'h5A;
        #12;
        probe(0, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL rst_dot0 got %h want %h", rgb24, 24'hC80000); end
        probe(0, 2); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL rst_dot1 got %h want %h", rgb24, 24'hC80000); end
        probe(0, 4); n_tests++;
        if (rgb24 !== 24'h00C800) begin n_fail++; $display("FAIL rst_dot2 got %h want %h", rgb24, 24'h00C800); end
        probe(0, 6); n_tests++;
        if (rgb24 !== 24'h0000C8) begin n_fail++; $display("FAIL rst_dot3 got %h want %h", rgb24, 24'h0000C8); end
        probe(1, 0); n_tests++;
        if (rgb24 !== 24'h000000) begin n_fail++; $display("FAIL rst_empty got %h want %h", rgb24, 24'h000000); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        probe(1, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL pre_midstep got %h want %h", rgb24, 24'hC80000); end
        // tick is live in this cycle; async reset must win
        @(posedge clk); #1;
        reset = 1'b1;
        probe(0, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL async_rst got %h want %h", rgb24, 24'hC80000); end
        @(posedge clk); #1;
        probe(1, 0); n_tests++;
        if (rgb24 !== 24'h000000) begin n_fail++; $display("FAIL rst_dominates got %h want %h", rgb24, 24'h000000); end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        probe(0, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL fresh_tick_wait got %h want %h", rgb24, 24'hC80000); end
        @(posedge clk); #1;
        probe(1, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL fresh_tick_step got %h want %h", rgb24, 24'hC80000); end
    endtask

    task automatic test_raster_step;
        do_reset(1'b1, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        probe(1, 0); n_tests++;
        if (rgb24 !== 24'h000000) begin n_fail++; $display("FAIL raster_early got %h want %h", rgb24, 24'h000000); end
        @(posedge clk); #1;
        probe(1, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL raster_1 got %h want %h", rgb24, 24'hC80000); end
        probe(0, 0); n_tests++;
        if (rgb24 !== TR0) begin n_fail++; $display("FAIL raster_left got %h want %h", rgb24, TR0); end
        repeat (4) @(posedge clk);
        #1;
        probe(2, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL raster_2 got %h want %h", rgb24, 24'hC80000); end
    endtask

    task automatic test_raster_wrap;
        do_reset(1'b1, 4'b0000);
        repeat (256) @(posedge clk);
        #1;
        probe(0, 1); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL raster_row got %h want %h", rgb24, 24'hC80000); end
        repeat (16380 - 256) @(posedge clk);
        #1;
        probe(63, 63); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL raster_corner got %h want %h", rgb24, 24'hC80000); end
        probe(0, 0); n_tests++;
        if (rgb24 !== 24'h000000) begin n_fail++; $display("FAIL raster_origin_empty got %h want %h", rgb24, 24'h000000); end
        repeat (4) @(posedge clk);
        #1;
        probe(0, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL raster_wrap got %h want %h", rgb24, 24'hC80000); end
        probe(63, 63); n_tests++;
        if (rgb24 !== TR0) begin n_fail++; $display("FAIL raster_corner_left got %h want %h", rgb24, TR0); end
        probe(0, 4); n_tests++;
        if (rgb24 !== 24'h00C800) begin n_fail++; $display("FAIL dot2_wrap got %h want %h", rgb24, 24'h00C800); end
    endtask

    task automatic test_bounce;
        do_reset(1'b1, 4'b0010);
        for (int f = 1; f <= 63; f++) begin
            frame = 13'(f);
            @(posedge clk); #1;
        end
        probe(63, 61); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL bounce_pre got %h want %h", rgb24, 24'hC80000); end
        probe(63, 6); n_tests++;
        if (rgb24 !== 24'h0000C8) begin n_fail++; $display("FAIL dot3_frame got %h want %h", rgb24, 24'h0000C8); end
        frame = 13'd64;
        @(posedge clk); #1;
        probe(62, 60); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL bounce_wall got %h want %h", rgb24, 24'hC80000); end
        probe(63, 61); n_tests++;
        if (rgb24 !== TR0) begin n_fail++; $display("FAIL bounce_left got %h want %h", rgb24, TR0); end
        frame = 13'd65;
        @(posedge clk); #1;
        probe(61, 59); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL bounce_dir got %h want %h", rgb24, 24'hC80000); end
    endtask

    task automatic test_overlap;
        do_reset(1'b1, 4'b0101);
        frame = 13'd1;
        @(posedge clk); #1;
        frame = 13'd2;
        @(posedge clk); #1;
        probe(2, 2); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL mode_raster got %h want %h", rgb24, 24'hC80000); end
        dot_mode = 4'b0111;
        frame = 13'd3;
        @(posedge clk); #1;
        frame = 13'd4;
        @(posedge clk); #1;
        probe(4, 4); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL mode_bounce got %h want %h", rgb24, 24'hC80000); end
        repeat (12) @(posedge clk);
        #1;
        probe(4, 4); n_tests++;
        if (rgb24 !== 24'hFF0000) begin n_fail++; $display("FAIL saturate got %h want %h", rgb24, 24'hFF0000); end
        probe(4, 8); n_tests++;
        if (rgb24 !== 24'h00C800) begin n_fail++; $display("FAIL dot2_bounce got %h want %h", rgb24, 24'h00C800); end
        probe(4, 6); n_tests++;
        if (rgb24 !== 24'h0000C8) begin n_fail++; $display("FAIL dot3_raster got %h want %h", rgb24, 24'h0000C8); end
    endtask

    task automatic test_run_gate;
        do_reset(1'b0, 4'b0000);
        frame = 13'd1;
        repeat (12) @(posedge clk);
        #1;
        probe(0, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL frozen_div got %h want %h", rgb24, 24'hC80000); end
        probe(1, 2); n_tests++;
        if (rgb24 !== 24'h000000) begin n_fail++; $display("FAIL frozen_frame got %h want %h", rgb24, 24'h000000); end
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        probe(0, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL no_queue got %h want %h", rgb24, 24'hC80000); end
        @(posedge clk); #1;
        probe(1, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL resume_step got %h want %h", rgb24, 24'hC80000); end
        probe(2, 0); n_tests++;
        if (rgb24 !== 24'h000000) begin n_fail++; $display("FAIL single_step got %h want %h", rgb24, 24'h000000); end
    endtask

`ifdef DOT_TRAIL_EN
    task automatic test_trail;
        do_reset(1'b1, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        probe(0, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL trail_invalid got %h want %h", rgb24, 24'hC80000); end
        @(posedge clk); #1;
        probe(0, 0); n_tests++;
        if (rgb24 !== 24'h640000) begin n_fail++; $display("FAIL trail_pix got %h want %h", rgb24, 24'h640000); end
        probe(1, 0); n_tests++;
        if (rgb24 !== 24'hC80000) begin n_fail++; $display("FAIL trail_head got %h want %h", rgb24, 24'hC80000); end
    endtask
`endif

    initial begin
        x = '0; y = '0; frame = '0; subframe = '0; run = 1'b0; dot_mode = '0; reset = 1'b1;
        test_reset();
        test_raster_step();
        test_raster_wrap();
        test_bounce();
        test_overlap();
        test_run_gate();
`ifdef DOT_TRAIL_EN
        test_trail();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_dot_painter.md
MULTI_DOT_PAINTER -- requirements
Module: multi_dot_painter

Interface
REQ-001 SHALL have parameter NUM_DOTS, default 4, number of independent dots (1..8).
REQ-002 SHALL have parameter WIDTH, default 64, panel columns; X coordinates span 0..WIDTH-1.
REQ-003 SHALL have parameter HEIGHT, default 64, panel rows; Y coordinates span 0..HEIGHT-1.
REQ-004 SHALL have parameter FRAME_BITS, default 13, width of the frame counter input.
REQ-005 SHALL have parameter DIV_MAX, default 240000, terminal count of the shared tick divider.
REQ-006 SHALL have parameter TICK_SEL, default 4'b1010, NUM_DOTS bits; bit i=1 steps dot i on frame change, 0 on divider tick.
REQ-007 SHALL have parameter DOT_COLORS, default {24'hC80000, 24'h00C800, 24'h0000C8, 24'hC8C800}, packed 24-bit RGB per dot, dot 0 in LSBs.
REQ-008 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-010 SHALL have port frame, input, FRAME_BITS, frame counter from the panel driver.
REQ-011 SHALL have port subframe, input, 8, PWM subframe index, accepted and unused.
REQ-012 SHALL have port x, input, 6, column being painted.
REQ-013 SHALL have port y, input, 6, row being painted.
REQ-014 SHALL have port run, input, 1, 1 = dots advance, 0 = all dots frozen.
REQ-015 SHALL have port dot_mode, input, NUM_DOTS, per-dot motion mode: 0 = RASTER, 1 = BOUNCE.
REQ-016 SHALL have port rgb24, output, 24, {red, green, blue} for pixel (x,y).

Function
REQ-017 SHALL count divider 0..DIV_MAX, asserting div_tick for one cycle at DIV_MAX and wrapping to 0 on the next cycle; divider counts regardless of run.
REQ-018 SHALL register last_frame and assert frame_tick for one cycle whenever frame != last_frame, updating last_frame on the same edge.
REQ-019 SHALL step dot i on the cycle after its selected tick when run=1; ticks arriving while run=0 are discarded, not queued.
REQ-020 RASTER step SHALL be x+1; at x=WIDTH-1 x wraps to 0 and y increments; at (WIDTH-1,HEIGHT-1) the dot wraps to (0,0).
REQ-021 BOUNCE step SHALL move x by dx and y by dy (each +1 or -1); at a wall in the direction of travel the sign flips and the dot moves one step inward on that same step.
REQ-022 A dot_mode change SHALL take effect at the next step with position and direction bits preserved; a RASTER step SHALL leave dx/dy unchanged.
REQ-023 rgb24 SHALL be combinational from x, y and registered state (zero latency): per-channel sum of DOT_COLORS of every dot at (x,y), saturating at 255.
REQ-024 With no dot at (x,y), rgb24 SHALL be 24'h000000.

Reset
REQ-025 Reset SHALL asynchronously clear the divider and last_frame to 0, and set dot i to x=0, y=(2*i) mod HEIGHT, dx=+1, dy=+1.
REQ-026 Reset asserted mid-step SHALL dominate; the first step after release requires a fresh tick.
REQ-027 During reset rgb24 SHALL reflect the reset positions.

Configuration
REQ-028 With DOT_TRAIL_EN defined, each dot SHALL keep its previous position plus a valid bit, cleared by reset and set on the first step; a valid trail adds (DOT_COLORS[i] per channel >>1) at that position into the saturating sum.
REQ-029 Without DOT_TRAIL_EN, no trail state SHALL exist and only current positions are painted.

Structure
REQ-030 The shared package SHALL hold the RASTER/BOUNCE mode constants, the 24-bit RGB type and the saturating 8-bit add function.
REQ-031 Per-dot state and stepping SHALL live in sub-module dot_walker, instantiated NUM_DOTS times by generate; divider, frame detection and colour summing stay in the top.

Verification
REQ-032 Reset, run=1, DIV_MAX=3, dot 0 RASTER -> dot 0 at (1,0) after first div_tick, (2,0) after second.
REQ-033 Dot 0 RASTER preloaded at (63,63) by stepping, one more tick -> (0,0).
REQ-034 Dot 1 BOUNCE at x=63, dx=+1, frame 5->6 -> x=62, dx=-1 next cycle.
REQ-035 Dots 0 and 1 both at (4,4), colors C80000 and C80000 -> rgb24=FF0000 (saturated).
REQ-036 run=0 across three ticks, then run=1 -> no movement until the next tick, then a single step.
REQ-037 DOT_TRAIL_EN, dot 0 RASTER steps (0,0)->(1,0) -> pixel (0,0)=640000, pixel (1,0)=C80000.
